// File: rtl/snd_vramctrl_if.sv
// AXI4 read-channel bundle (AR + R) between the sound VRAM fetcher and the memory side.
interface snd_vramctrl_if;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/snd_vramctrl.sv
// AXI4 read master streaming sound samples from VRAM into the sound FIFO,
// one INCR burst at a time, gated by FIFO fill level and playback state.
module snd_vramctrl #(
    parameter logic [9:0] FIFO_THRESH = 10'd960
) (
    input  logic           ACLK,
    input  logic           ARST_N,
    input  logic           RST,
    input  logic           PLAY,
    input  logic [31:0]    ADDR,
    input  logic [7:0]     LEN,
    input  logic           REM_EMPTY,
    input  logic [9:0]     WR_DATA_CNT,
    input  logic           FIFO_FIN,
    output logic           FIFO_WR,
    output logic [31:0]    FIFO_DIN,
    output logic           BUSY,
    output logic           ERR,
    snd_vramctrl_if.master axi
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARREQ  = 2'd1,
        ST_RDATA  = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic        discard_q, discard_d;
    logic        err_q, err_d;
    logic        fifo_wr_q, fifo_wr_d;
    logic [31:0] fifo_din_q, fifo_din_d;

    logic issue;
    logic beat;
    logic beat_err;

    assign issue = (state_q == ST_IDLE) && PLAY && !RST && !REM_EMPTY && !FIFO_FIN
                   && (WR_DATA_CNT <= FIFO_THRESH);
    // RREADY is high throughout RDATA, so RVALID alone marks an accepted beat.
    assign beat  = (state_q == ST_RDATA) && axi.RVALID;
    assign beat_err = (axi.RRESP != 2'b00)
                      || ( axi.RLAST && (beat_cnt_q != arlen_q))
                      || (!axi.RLAST && (beat_cnt_q == arlen_q));

    // State register and datapath flops.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q    <= ST_IDLE;
            araddr_q   <= '0;
            arlen_q    <= '0;
            beat_cnt_q <= '0;
            discard_q  <= 1'b0;
            err_q      <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_din_q <= '0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            beat_cnt_q <= beat_cnt_d;
            discard_q  <= discard_d;
            err_q      <= err_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_din_q <= fifo_din_d;
        end
    end

    // Next-state logic. AR is never withdrawn, so soft reset only flags the burst for discard.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (issue)                 state_d = ST_ARREQ;
            ST_ARREQ:  if (axi.ARREADY)           state_d = ST_RDATA;
            ST_RDATA:  if (beat && axi.RLAST)     state_d = ST_SETTLE;
            ST_SETTLE:                            state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: address latch, beat counting, discard, error and FIFO push.
    always_comb begin
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        beat_cnt_d = beat_cnt_q;
        discard_d  = discard_q;
        err_d      = err_q;
        fifo_wr_d  = 1'b0;
        fifo_din_d = fifo_din_q;

        if (issue) begin
            araddr_d   = ADDR;
            arlen_d    = LEN;
            beat_cnt_d = '0;
            discard_d  = 1'b0;
        end else begin
            if (beat)
                beat_cnt_d = beat_cnt_q + 8'd1;
            if (RST && ((state_q == ST_ARREQ) || (state_q == ST_RDATA)))
                discard_d = 1'b1;
        end

        if (RST)
            err_d = 1'b0;
        else if (beat && beat_err)
            err_d = 1'b1;

        // A beat arriving in the same cycle as the soft reset is already discarded.
        if (beat && !discard_q && !RST) begin
            fifo_wr_d  = 1'b1;
            fifo_din_d = axi.RDATA;
        end
    end

    // Output logic.
    always_comb begin
        axi.ARVALID = (state_q == ST_ARREQ);
        axi.RREADY  = (state_q == ST_RDATA);
        BUSY        = (state_q != ST_IDLE);
    end

    assign axi.ARADDR  = araddr_q;
    assign axi.ARLEN   = arlen_q;
    assign axi.ARSIZE  = 3'b010;
    assign axi.ARBURST = 2'b01;
    assign FIFO_WR     = fifo_wr_q;
    assign FIFO_DIN    = fifo_din_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_snd_vramctrl.sv
// Directed bench for snd_vramctrl: bursts, backpressure, error flags, soft and async reset.
module tb_snd_vramctrl;

    logic        ACLK = 1'b0;
    logic        ARST_N = 1'b0;
    logic        RST = 1'b0;
    logic        PLAY = 1'b0;
    logic [31:0] ADDR = '0;
    logic [7:0]  LEN = '0;
    logic        REM_EMPTY = 1'b0;
    logic [9:0]  WR_DATA_CNT = '0;
    logic        FIFO_FIN = 1'b0;
    logic        FIFO_WR;
    logic [31:0] FIFO_DIN;
    logic        BUSY;
    logic        ERR;

    snd_vramctrl_if axi();

    snd_vramctrl #(.FIFO_THRESH(10'd960)) dut (
        .ACLK        (ACLK),
        .ARST_N      (ARST_N),
        .RST         (RST),
        .PLAY        (PLAY),
        .ADDR        (ADDR),
        .LEN         (LEN),
        .REM_EMPTY   (REM_EMPTY),
        .WR_DATA_CNT (WR_DATA_CNT),
        .FIFO_FIN    (FIFO_FIN),
        .FIFO_WR     (FIFO_WR),
        .FIFO_DIN    (FIFO_DIN),
        .BUSY        (BUSY),
        .ERR         (ERR),
        .axi         (axi)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] wr_q[$];
    int          wr_cyc[$];

    // FIFO-side monitor: every strobe observed at a falling edge is one pushed word.
    always @(negedge ACLK) begin
        cyc = cyc + 1;
        if (FIFO_WR === 1'b1) begin
            wr_q.push_back(FIFO_DIN);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wr_q.delete();
        wr_cyc.delete();
    endtask

    task automatic wait_arvalid(output int n);
        n = 0;
        while (axi.ARVALID !== 1'b1 && n < 64) begin
            @(negedge ACLK);
            n++;
        end
    endtask

    task automatic start_burst(input logic [31:0] addr, input logic [7:0] len, output int n);
        ADDR = addr;
        LEN  = len;
        PLAY = 1'b1;
        wait_arvalid(n);
    endtask

    // Drives n beats back to back, RLAST on the final one; optional bad RRESP / RST beat.
    task automatic send_beats(input int n, input int resp_beat, input int rst_beat,
                              input logic [31:0] seed, output int rready_miss);
        rready_miss = 0;
        for (int i = 0; i < n; i++) begin
            if (axi.RREADY !== 1'b1) rready_miss++;
            axi.RVALID = 1'b1;
            axi.RDATA  = seed + 32'(i);
            axi.RRESP  = (i == resp_beat) ? 2'b10 : 2'b00;
            axi.RLAST  = (i == n - 1);
            RST        = (i == rst_beat);
            @(negedge ACLK);
        end
        axi.RVALID = 1'b0;
        axi.RLAST  = 1'b0;
        axi.RRESP  = 2'b00;
        RST        = 1'b0;
    endtask

    function automatic int count_bad(input logic [31:0] seed);
        int bad = 0;
        for (int i = 0; i < wr_q.size(); i++)
            if (wr_q[i] !== seed + 32'(i)) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge ACLK);
        checks++;
        if ({axi.ARVALID, axi.RREADY, FIFO_WR, BUSY, ERR} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {axi.ARVALID, axi.RREADY, FIFO_WR, BUSY, ERR});
        end
        checks++;
        if ({axi.ARSIZE, axi.ARBURST, axi.ARADDR, axi.ARLEN, FIFO_DIN} !== {3'b010, 2'b01, 32'h0, 8'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_data: size=%b burst=%b addr=%h len=%0d din=%h", axi.ARSIZE, axi.ARBURST,
                     axi.ARADDR, axi.ARLEN, FIFO_DIN);
        end
        ARST_N = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic test_full_burst();
        int n, miss, bad;
        WR_DATA_CNT = 10'd0;
        REM_EMPTY   = 1'b0;
        axi.ARREADY = 1'b1;
        start_burst(32'h1000_0000, 8'd31, n);
        checks++;
        if ({axi.ARVALID, axi.ARADDR, axi.ARLEN} !== {1'b1, 32'h1000_0000, 8'd31}) begin
            errors++;
            $display("FAIL full_ar: valid=%b addr=%h len=%0d want 1 10000000 31", axi.ARVALID, axi.ARADDR, axi.ARLEN);
        end
        @(negedge ACLK);
        clear_mon();
        send_beats(32, -1, -1, 32'hC0DE_0000, miss);
        ADDR = 32'h1000_0080;
        LEN  = 8'd3;
        // RLAST edge -> SETTLE -> IDLE -> ARVALID: two more falling edges after this one.
        wait_arvalid(n);
        checks++;
        if (n !== 2 || axi.ARVALID !== 1'b1) begin
            errors++;
            $display("FAIL full_gap: arvalid after %0d falling edges, want 2", n);
        end
        bad = count_bad(32'hC0DE_0000);
        checks++;
        if (wr_q.size() !== 32 || bad !== 0 || miss !== 0) begin
            errors++;
            $display("FAIL full_data: writes=%0d bad=%0d rready_miss=%0d want 32 0 0", wr_q.size(), bad, miss);
        end
        checks++;
        if (wr_cyc.size() != 32 || wr_cyc[31] - wr_cyc[0] !== 31) begin
            errors++;
            $display("FAIL full_no_bubble: write span=%0d cycles want 31",
                     (wr_cyc.size() == 32) ? wr_cyc[31] - wr_cyc[0] : -1);
        end
    endtask

    task automatic test_tail_burst();
        int miss, bad, extra;
        checks++;
        if ({axi.ARADDR, axi.ARLEN} !== {32'h1000_0080, 8'd3}) begin
            errors++;
            $display("FAIL tail_ar: addr=%h len=%0d want 10000080 3", axi.ARADDR, axi.ARLEN);
        end
        @(negedge ACLK);
        clear_mon();
        send_beats(4, -1, -1, 32'h7A11_0000, miss);
        REM_EMPTY = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge ACLK);
            if (axi.ARVALID === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL tail_stop: arvalid cycles=%0d busy=%b want 0 0", extra, BUSY);
        end
        bad = count_bad(32'h7A11_0000);
        checks++;
        if (wr_q.size() !== 4 || bad !== 0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL tail_data: writes=%0d bad=%0d err=%b want 4 0 0", wr_q.size(), bad, ERR);
        end
    endtask

    task automatic test_backpressure();
        int hits, moved, miss;
        REM_EMPTY   = 1'b0;
        WR_DATA_CNT = 10'd961;
        axi.ARREADY = 1'b0;
        ADDR        = 32'h2000_0000;
        LEN         = 8'd7;
        PLAY        = 1'b1;
        hits = 0;
        repeat (6) begin
            @(negedge ACLK);
            if (axi.ARVALID === 1'b1 || BUSY === 1'b1) hits++;
        end
        checks++;
        if (hits !== 0) begin
            errors++;
            $display("FAIL bp_961: issued during %0d cycles want 0", hits);
        end
        WR_DATA_CNT = 10'd960;
        @(negedge ACLK);
        checks++;
        if ({axi.ARVALID, axi.ARADDR, axi.ARLEN} !== {1'b1, 32'h2000_0000, 8'd7}) begin
            errors++;
            $display("FAIL bp_960: valid=%b addr=%h len=%0d want 1 20000000 7", axi.ARVALID, axi.ARADDR, axi.ARLEN);
        end
        moved = 0;
        repeat (5) begin
            ADDR = ADDR + 32'h40;
            LEN  = LEN + 8'd1;
            @(negedge ACLK);
            if ({axi.ARVALID, axi.ARADDR, axi.ARLEN} !== {1'b1, 32'h2000_0000, 8'd7}) moved++;
        end
        checks++;
        if (moved !== 0) begin
            errors++;
            $display("FAIL bp_hold: AR changed in %0d of 5 stalled cycles want 0", moved);
        end
        axi.ARREADY = 1'b1;
        PLAY        = 1'b0;
        @(negedge ACLK);
        checks++;
        if ({axi.ARVALID, axi.RREADY} !== 2'b01) begin
            errors++;
            $display("FAIL bp_rready: arvalid=%b rready=%b want 0 1", axi.ARVALID, axi.RREADY);
        end
        clear_mon();
        send_beats(8, -1, -1, 32'h0BB0_0000, miss);
        repeat (3) @(negedge ACLK);
        checks++;
        if (wr_q.size() !== 8 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL bp_burst: writes=%0d busy=%b want 8 0", wr_q.size(), BUSY);
        end
        WR_DATA_CNT = 10'd0;
    endtask

    task automatic test_errors();
        int n, miss;
        start_burst(32'h3000_0000, 8'd31, n);
        @(negedge ACLK);
        PLAY = 1'b0;
        clear_mon();
        send_beats(32, 7, -1, 32'hE770_0000, miss);
        repeat (2) @(negedge ACLK);
        checks++;
        if (ERR !== 1'b1 || wr_q.size() !== 32 || count_bad(32'hE770_0000) !== 0) begin
            errors++;
            $display("FAIL err_rresp: err=%b writes=%0d want 1 32", ERR, wr_q.size());
        end
        RST = 1'b1;
        @(negedge ACLK);
        RST = 1'b0;
        checks++;
        if (ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b want 0", ERR);
        end
        start_burst(32'h3000_1000, 8'd31, n);
        @(negedge ACLK);
        PLAY = 1'b0;
        send_beats(4, -1, -1, 32'hE771_0000, miss);
        repeat (3) @(negedge ACLK);
        checks++;
        if ({ERR, BUSY} !== 2'b10) begin
            errors++;
            $display("FAIL err_early_last: err=%b busy=%b want 1 0", ERR, BUSY);
        end
        RST = 1'b1;
        @(negedge ACLK);
        RST = 1'b0;
        start_burst(32'h3000_2000, 8'd1, n);
        @(negedge ACLK);
        PLAY = 1'b0;
        send_beats(3, -1, -1, 32'hE772_0000, miss);
        repeat (3) @(negedge ACLK);
        checks++;
        if ({ERR, BUSY} !== 2'b10) begin
            errors++;
            $display("FAIL err_overrun: err=%b busy=%b want 1 0", ERR, BUSY);
        end
    endtask

    task automatic test_soft_reset();
        int n, miss, bad;
        RST = 1'b1;
        @(negedge ACLK);
        RST = 1'b0;
        start_burst(32'h4000_0000, 8'd31, n);
        @(negedge ACLK);
        PLAY = 1'b0;
        clear_mon();
        send_beats(32, -1, 10, 32'h50F7_0000, miss);
        repeat (3) @(negedge ACLK);
        bad = count_bad(32'h50F7_0000);
        checks++;
        if (wr_q.size() !== 10 || bad !== 0 || miss !== 0) begin
            errors++;
            $display("FAIL soft_rst_data: writes=%0d bad=%0d rready_miss=%0d want 10 0 0", wr_q.size(), bad, miss);
        end
        checks++;
        if ({BUSY, ERR, axi.ARVALID} !== 3'b000) begin
            errors++;
            $display("FAIL soft_rst_idle: busy=%b err=%b arvalid=%b want 000", BUSY, ERR, axi.ARVALID);
        end
    endtask

    task automatic test_async_reset();
        int n;
        start_burst(32'h5000_0000, 8'd31, n);
        @(negedge ACLK);
        PLAY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            axi.RVALID = 1'b1;
            axi.RDATA  = 32'hA5A5_0000 + 32'(i);
            axi.RRESP  = (i == 0) ? 2'b10 : 2'b00;
            axi.RLAST  = 1'b0;
            @(negedge ACLK);
        end
        checks++;
        if ({ERR, FIFO_WR, BUSY, axi.RREADY} !== 4'b1111) begin
            errors++;
            $display("FAIL arst_pre: err=%b wr=%b busy=%b rready=%b want 1111", ERR, FIFO_WR, BUSY, axi.RREADY);
        end
        #2;
        ARST_N = 1'b0;
        #1;
        checks++;
        if ({axi.ARVALID, axi.RREADY, FIFO_WR, BUSY, ERR, axi.ARSIZE, axi.ARBURST} !== {5'b00000, 3'b010, 2'b01}) begin
            errors++;
            $display("FAIL arst_now: av=%b rr=%b wr=%b busy=%b err=%b size=%b burst=%b", axi.ARVALID,
                     axi.RREADY, FIFO_WR, BUSY, ERR, axi.ARSIZE, axi.ARBURST);
        end
        axi.RVALID = 1'b0;
        axi.RRESP  = 2'b00;
        @(negedge ACLK);
        ARST_N = 1'b1;
        repeat (2) @(negedge ACLK);
        checks++;
        if ({BUSY, axi.ARVALID, FIFO_WR} !== 3'b000) begin
            errors++;
            $display("FAIL arst_after: busy=%b arvalid=%b wr=%b want 000", BUSY, axi.ARVALID, FIFO_WR);
        end
    endtask

    initial begin
        axi.ARREADY = 1'b1;
        axi.RDATA   = '0;
        axi.RRESP   = 2'b00;
        axi.RLAST   = 1'b0;
        axi.RVALID  = 1'b0;
        test_reset();
        test_full_burst();
        test_tail_burst();
        test_backpressure();
        test_errors();
        test_soft_reset();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
